// File: rtl/board_scanner_pkg.sv
// Shared board geometry, xvga count types and the timing bundle carried
// alongside each pixel through the scanner.
package board_scanner_pkg;
  localparam int BOARD_SIZE       = 512;
  localparam int LOG_BOARD_SIZE   = $clog2(BOARD_SIZE);
  localparam int HCOUNT_WIDTH     = 11;
  localparam int VCOUNT_WIDTH     = 10;
  localparam int WORD_WIDTH       = 16;
  localparam int WORD_IDX_WIDTH   = 2 * LOG_BOARD_SIZE - $clog2(WORD_WIDTH);
  localparam int BOARD_ADDR_WIDTH = 1 + WORD_IDX_WIDTH;

  typedef logic [HCOUNT_WIDTH-1:0]     hcount_t;
  typedef logic [VCOUNT_WIDTH-1:0]     vcount_t;
  typedef logic [BOARD_ADDR_WIDTH-1:0] board_addr_t;

  typedef struct packed {
    hcount_t hcount;
    vcount_t vcount;
  } pos_t;

  typedef struct packed {
    pos_t pos;
    logic hsync;
    logic vsync;
    logic blank;
  } timing_t;

  // Blanked, sync-inactive pixel at the origin.
  localparam timing_t TIMING_RESET = '{pos: '0, hsync: 1'b1, vsync: 1'b1, blank: 1'b1};

  function automatic logic in_board(input hcount_t h, input vcount_t v);
    return (h < hcount_t'(BOARD_SIZE)) && (v < vcount_t'(BOARD_SIZE));
  endfunction
endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipeline with synchronous reset to a constant.
module delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= {DEPTH{RESET_VALUE}};
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/board_scanner.sv
// Raster-order board reader: fetches one BRAM word per WORD_WIDTH pixels and
// presents per-pixel cell state aligned with the delayed xvga timing.
module board_scanner #(
  parameter  int WORD_WIDTH   = board_scanner_pkg::WORD_WIDTH,
  parameter  int READ_LATENCY = 2,
  localparam int LW           = $clog2(WORD_WIDTH),
  localparam int AW           = 1 + 2 * board_scanner_pkg::LOG_BOARD_SIZE - LW
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  board_scanner_pkg::hcount_t hcount_in,
  input  board_scanner_pkg::vcount_t vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       blank_in,
  input  logic                       buf_sel_in,
  output logic                       rd_en_out,
  output logic [AW-1:0]              rd_addr_out,
  input  logic [WORD_WIDTH-1:0]      rd_data_in,
  output logic                       cell_alive_out,
  output board_scanner_pkg::hcount_t hcount_out,
  output board_scanner_pkg::vcount_t vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       blank_out,
  output logic                       frame_done_out
);
  import board_scanner_pkg::*;

  localparam int WIDX_W = AW - 1;
  localparam int WPR    = BOARD_SIZE / WORD_WIDTH;
  localparam int L      = READ_LATENCY + 1;

  typedef struct packed {
    logic          fetch;
    logic [LW-1:0] low;
    logic          vis;
    logic          last;
  } tag_t;

  timing_t             tim_d, tim_q;
  tag_t                tag_d, tag_q;
  logic                first_px, inb, buf_eff;
  logic [WIDX_W-1:0]   word_idx;
  logic [WORD_WIDTH-1:0] sel_word;

  logic                buf_q, frame_valid_q, rd_en_q, cell_alive_q, frame_done_q;
  logic [AW-1:0]       rd_addr_q;
  logic [WORD_WIDTH-1:0] cur_word_q;

  always_comb begin
    first_px = (hcount_in == '0) && (vcount_in == '0);
    inb      = in_board(hcount_in, vcount_in);
    // The origin fetch already uses the buffer being latched this cycle.
    buf_eff  = first_px ? buf_sel_in : buf_q;
    word_idx = WIDX_W'(vcount_in[LOG_BOARD_SIZE-1:0]) * WIDX_W'(WPR)
             + WIDX_W'(hcount_in[LOG_BOARD_SIZE-1:0] >> LW);
    tag_d.fetch = inb && (hcount_in[LW-1:0] == '0);
    tag_d.low   = hcount_in[LW-1:0];
    tag_d.vis   = inb && !blank_in;
    tag_d.last  = (hcount_in == hcount_t'(BOARD_SIZE - 1)) &&
                  (vcount_in == vcount_t'(BOARD_SIZE - 1));
    tim_d = '{pos: '{hcount: hcount_in, vcount: vcount_in},
              hsync: hsync_in, vsync: vsync_in, blank: blank_in};
    // Word arriving this cycle is used directly; later pixels use the copy.
    sel_word = tag_q.fetch ? rd_data_in : cur_word_q;
  end

  delay_line #(.WIDTH($bits(timing_t)), .DEPTH(L), .RESET_VALUE(TIMING_RESET)) u_tim_dly (
    .clk_i(clk_in), .rst_i(rst_in), .d_i(tim_d), .q_o(tim_q)
  );

  delay_line #(.WIDTH($bits(tag_t)), .DEPTH(READ_LATENCY), .RESET_VALUE('0)) u_tag_dly (
    .clk_i(clk_in), .rst_i(rst_in), .d_i(tag_d), .q_o(tag_q)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      buf_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      cur_word_q    <= '0;
      cell_alive_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      if (first_px) buf_q <= buf_sel_in;
      rd_en_q <= tag_d.fetch;
      if (tag_d.fetch) rd_addr_q <= {buf_eff, word_idx};
      if (tag_q.fetch) cur_word_q <= rd_data_in;
      cell_alive_q <= tag_q.vis && sel_word[tag_q.low];
      frame_done_q <= tag_q.last && frame_valid_q;
      if (first_px) frame_valid_q <= 1'b1;
      else if (tag_q.last && frame_valid_q) frame_valid_q <= 1'b0;
    end
  end

  assign rd_en_out      = rd_en_q;
  assign rd_addr_out    = rd_addr_q;
  assign cell_alive_out = cell_alive_q;
  assign frame_done_out = frame_done_q;
  assign hcount_out     = tim_q.pos.hcount;
  assign vcount_out     = tim_q.pos.vcount;
  assign hsync_out      = tim_q.hsync;
  assign vsync_out      = tim_q.vsync;
  assign blank_out      = tim_q.blank;
endmodule

// File: tb/tb_board_scanner.sv
// Scoreboard bench for board_scanner with a behavioural two-buffer board BRAM
// and 1024x768 xvga timing driven over selected board rows.
module tb_board_scanner;
  import board_scanner_pkg::*;

  localparam int AW = BOARD_ADDR_WIDTH;
  localparam int WW = 16;

  logic          clk = 1'b0, rst = 1'b1;
  hcount_t       hcount_in = '0, hcount_out;
  vcount_t       vcount_in = '0, vcount_out;
  logic          hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b1, buf_sel_in = 1'b0;
  logic          rd_en_out, cell_alive_out, hsync_out, vsync_out, blank_out, frame_done_out;
  logic [AW-1:0] rd_addr_out;
  logic [WW-1:0] rd_data_in;

  always #5 clk = ~clk;

  board_scanner #(.WORD_WIDTH(WW), .READ_LATENCY(2)) dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in), .buf_sel_in(buf_sel_in),
    .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .cell_alive_out(cell_alive_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .frame_done_out(frame_done_out)
  );

  // Board BRAM: address registered by the scanner, one more stage here.
  logic [WW-1:0] mem [0:(1<<AW)-1];
  logic [WW-1:0] bram_q = '0;
  always @(posedge clk) if (rd_en_out) bram_q <= mem[rd_addr_out];
  assign rd_data_in = bram_q;

  typedef struct packed {
    hcount_t h; vcount_t v; logic hs, vs, bl, alive, fd;
  } px_exp_t;
  typedef struct packed { logic en; logic [AW-1:0] addr; } rd_exp_t;

  localparam px_exp_t R_EXP = '{h: '0, v: '0, hs: 1'b1, vs: 1'b1, bl: 1'b1, alive: 1'b0, fd: 1'b0};

  px_exp_t px_q[$];
  rd_exp_t rd_q[$];
  int n_chk = 0, n_fail = 0;
  int alive_cnt, alive_last, fd_cnt, fd_last, rd_cnt, rd_msb_cnt;
  int row0[3];
  logic cur_sel = 1'b0, exp_buf = 1'b0, exp_fv = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    alive_cnt = 0; alive_last = 0; fd_cnt = 0; fd_last = 0; rd_cnt = 0; rd_msb_cnt = 0;
    for (int i = 0; i < 3; i++) row0[i] = 2;
  endtask

  task automatic fill(input logic [WW-1:0] b0, input logic [WW-1:0] b1);
    for (int i = 0; i < (1 << AW); i++) mem[i] = (i < (1 << (AW-1))) ? b0 : b1;
  endtask

  // One pixel per call; expectations come from the bench memory and buffer model.
  task automatic drive(input int x, input int y, input bit fblank = 1'b0);
    px_exp_t e; rd_exp_t r; logic first, inb, bl, beff; int idx;
    @(negedge clk);
    if (rst) begin
      rst = 1'b0;
      px_q.push_back(R_EXP);
      px_q.push_back(R_EXP);
    end
    bl = (x >= 1024) || (y >= 768) || fblank;
    hcount_in = hcount_t'(x); vcount_in = vcount_t'(y);
    hsync_in = !(x >= 1048 && x < 1184);
    vsync_in = !(y >= 771 && y < 777);
    blank_in = bl; buf_sel_in = cur_sel;
    first = (x == 0) && (y == 0);
    beff = first ? cur_sel : exp_buf;
    if (first) begin exp_buf = cur_sel; exp_fv = 1'b1; end
    inb = (x < BOARD_SIZE) && (y < BOARD_SIZE);
    idx = y * 32 + x / 16;
    r.en = inb && (x % 16 == 0);
    r.addr = {beff, (AW-1)'(idx)};
    e.h = hcount_in; e.v = vcount_in; e.hs = hsync_in; e.vs = vsync_in; e.bl = bl;
    e.alive = inb && !bl && mem[r.addr][x % 16];
    e.fd = (x == 511) && (y == 511) && exp_fv;
    if (e.fd) exp_fv = 1'b0;
    px_q.push_back(e);
    rd_q.push_back(r);
  endtask

  task automatic scan(input int y, input int x0, input int x1, input bit fblank = 1'b0);
    for (int x = x0; x <= x1; x++) drive(x, y, fblank);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1300, 800);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      px_q.delete(); rd_q.delete();
      exp_buf = 1'b0; exp_fv = 1'b0;
      px_q.push_back(R_EXP);
      rd_q.push_back('{en: 1'b0, addr: '0});
    end
    @(posedge clk); #1;
    check("rst_rd_addr", int'(rd_addr_out), 0);
  endtask

  // Monitor: pops one expectation per cycle from each queue.
  initial forever begin
    px_exp_t e, a; rd_exp_t r;
    @(posedge clk); #1;
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      n_chk++;
      if (rd_en_out !== r.en || (r.en && rd_addr_out !== r.addr)) begin
        n_fail++;
        if (n_fail <= 40)
          $display("FAIL rd_port: got en=%b addr=%h, expected en=%b addr=%h",
                   rd_en_out, rd_addr_out, r.en, r.addr);
      end
      if (rd_en_out === 1'b1) begin
        rd_cnt++;
        if (rd_addr_out[AW-1]) rd_msb_cnt++;
      end
    end
    if (px_q.size() > 0) begin
      e = px_q.pop_front();
      a = '{h: hcount_out, v: vcount_out, hs: hsync_out, vs: vsync_out, bl: blank_out,
            alive: cell_alive_out, fd: frame_done_out};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        if (n_fail <= 40)
          $display("FAIL pixel: got h=%0d v=%0d hs=%b vs=%b bl=%b alive=%b fd=%b, expected h=%0d v=%0d hs=%b vs=%b bl=%b alive=%b fd=%b",
                   a.h, a.v, a.hs, a.vs, a.bl, a.alive, a.fd, e.h, e.v, e.hs, e.vs, e.bl, e.alive, e.fd);
      end
      if (cell_alive_out === 1'b1) begin
        alive_cnt++;
        if (hcount_out == 511 && vcount_out == 511) alive_last++;
      end
      if (frame_done_out === 1'b1) begin
        fd_cnt++;
        if (hcount_out == 511 && vcount_out == 511) fd_last++;
      end
      if (blank_out === 1'b0 && vcount_out == 0 && hcount_out < 3) row0[hcount_out] = int'(cell_alive_out);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill(16'h5555, 16'h5555);
    clear_counts();
    do_reset(4);

    // Checkerboard: full row 0, then an off-board row and a forced-blank span.
    clear_counts();
    scan(0, 0, 1343);
    idle(4);
    check("cb_x0", row0[0], 1);
    check("cb_x1", row0[1], 0);
    check("cb_x2", row0[2], 1);
    check("cb_row0_reads", rd_cnt, 32);
    check("cb_row0_alive", alive_cnt, 256);
    clear_counts();
    scan(600, 0, 600);
    scan(5, 512, 700);
    idle(4);
    check("offboard_reads", rd_cnt, 0);
    check("offboard_alive", alive_cnt, 0);
    clear_counts();
    scan(5, 0, 31, 1'b1);
    idle(4);
    check("blank_reads", rd_cnt, 2);
    check("blank_alive", alive_cnt, 0);

    // Single live cell at (511,511) in buffer 0.
    fill(16'h0000, 16'h0000);
    mem[511*32 + 31] = 16'h8000;
    cur_sel = 1'b0;
    clear_counts();
    scan(0, 0, 15);
    scan(510, 480, 543);
    scan(511, 0, 1343);
    scan(512, 496, 527);
    idle(4);
    check("single_alive", alive_cnt, 1);
    check("single_alive_pos", alive_last, 1);
    check("single_fd", fd_cnt, 1);
    check("single_fd_pos", fd_last, 1);
    clear_counts();
    scan(511, 496, 527);
    idle(4);
    check("no_fd_without_origin", fd_cnt, 0);
    check("single_alive_rescan", alive_cnt, 1);

    // Buffer swap: toggle at (100,100) only takes effect at the next origin.
    fill(16'h0000, 16'hffff);
    cur_sel = 1'b0;
    clear_counts();
    scan(0, 0, 31);
    scan(100, 96, 99);
    cur_sel = 1'b1;
    scan(100, 100, 127);
    scan(511, 480, 543);
    idle(4);
    check("swap_mid_alive", alive_cnt, 0);
    check("swap_mid_msb", rd_msb_cnt, 0);
    check("swap_mid_fd", fd_cnt, 1);
    clear_counts();
    scan(0, 0, 1343);
    idle(4);
    check("swap_next_alive", alive_cnt, 512);
    check("swap_next_reads", rd_cnt, 32);
    check("swap_next_msb", rd_msb_cnt, 32);

    // Reset at (200,300): in-flight pixels dropped, buffer reverts to 0.
    clear_counts();
    scan(0, 0, 15);
    scan(300, 192, 200);
    do_reset(5);
    scan(300, 208, 255);
    scan(511, 496, 527);
    idle(4);
    check("rst_alive", alive_cnt, 16 + 7);
    check("rst_no_fd", fd_cnt, 0);
    clear_counts();
    scan(0, 0, 15);
    scan(511, 496, 511);
    idle(4);
    check("rst_frame_alive", alive_cnt, 32);
    check("rst_frame_fd", fd_cnt, 1);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", px_q.size() + rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
